// File: rtl/uart_rx_key_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_key_pkg
//  Description : Constants shared by the keypad UART receive and transmit
//                paths: ASCII key codes, oversampling ratio, receiver FSM
//                state encoding and small decode helpers.
//  Revision    : 1.0  initial release
// ============================================================================
package uart_rx_key_pkg;

  // Oversampling ratio of the receive sampler (fixed)
  localparam int OVERSAMPLE = 16;

  // Width of the per-bit sample counter and the sample index at bit centre
  localparam int          SAMPLE_CNT_W = 4;
  localparam logic [3:0]  MID_SAMPLE   = 4'd8;
  localparam logic [3:0]  SAMP_LAST    = 4'(OVERSAMPLE - 1);

  // ASCII codes produced by keys 1..4
  localparam logic [7:0]  KEY1_ASCII = 8'd49;
  localparam logic [7:0]  KEY2_ASCII = 8'd50;
  localparam logic [7:0]  KEY3_ASCII = 8'd51;
  localparam logic [7:0]  KEY4_ASCII = 8'd52;

  // Receiver FSM encoding
  localparam int STATE_W = 3;
  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_START     = 3'd1;
  localparam state_t ST_DATA      = 3'd2;
  localparam state_t ST_STOP      = 3'd3;
  localparam state_t ST_WAIT_IDLE = 3'd4;

  // One-hot key decode: bit0 = '1' .. bit3 = '4', zero for any other byte
  function automatic logic [3:0] key_decode(input logic [7:0] b);
    logic [3:0] k;
    k = 4'b0000;
    case (b)
      KEY1_ASCII: k = 4'b0001;
      KEY2_ASCII: k = 4'b0010;
      KEY3_ASCII: k = 4'b0100;
      KEY4_ASCII: k = 4'b1000;
      default:    k = 4'b0000;
    endcase
    return k;
  endfunction

  // Two-out-of-three majority vote
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================================
//  Module      : uart_baud_tick
//  Description : Oversampling tick generator. Emits a 1-cycle tick every
//                DIV = CLK_FREQ/(BAUD*OVERSAMPLE) clocks; restart realigns the
//                phase so the first tick lands DIV clocks after the restart.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_baud_tick
  import uart_rx_key_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600
) (
  input  logic clk_50MHz,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  // Divider ratio (integer floor); must be at least 1
  localparam int DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_tick;

  // Free-running divider, reloaded to zero on restart
  always_ff @(posedge clk_50MHz) begin
    if (rst || restart) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (r_cnt == DIV_LAST) begin
      r_cnt  <= '0;
      r_tick <= 1'b1;
    end else begin
      r_cnt  <= r_cnt + 1'b1;
      r_tick <= 1'b0;
    end
  end

  assign tick = r_tick;

endmodule
`default_nettype wire

// File: rtl/uart_rx_key.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_key
//  Description : 16x oversampling 8N1 UART receiver. Presents each good byte
//                with a 1-cycle uart_rdsig strobe, flags bad stop bits with
//                frame_err, and decodes ASCII '1'..'4' into a one-hot key_hit.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx_key
  import uart_rx_key_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       clk_50MHz,
  input  logic       rst,
  input  logic       uart_rx,
  output logic [7:0] uart_dataout,
  output logic       uart_rdsig,
  output logic       frame_err,
  output logic [3:0] key_hit,
  output logic       busy
);

  // Bit-period positions within a frame: 0 = start, 1..8 = data, 9 = stop
  localparam logic [3:0] LAST_DATA_POS = 4'd8;

  // Synchronizer and edge detect
  logic r_sync1;
  logic r_sync2;
  logic r_rx_prev;
  logic w_rx;
  logic w_fall;
  logic w_start_det;

  // Timing
  logic                    w_tick;
  logic [SAMPLE_CNT_W-1:0] r_samp_cnt;   // index of the most recent sample
  logic [3:0]              r_bit_pos;
  logic                    w_samp_mid;   // this tick takes sample 8
  logic                    w_samp_late;  // this tick takes sample 9 (vote window complete)

  // Data path
  logic [1:0] r_win;                     // samples 7 and 8 of the current bit
  logic       w_vote;
  logic [7:0] r_shift;
  logic [3:0] r_high_cnt;

  // FSM
  state_t r_state;
  state_t w_state_next;

  // Output decode and registers
  logic       w_byte_ok;
  logic       w_byte_bad;
  logic [3:0] w_key_next;
  logic [7:0] r_dataout;
  logic       r_rdsig;
  logic       r_ferr;
  logic [3:0] r_key;

  uart_baud_tick #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) u_baud_tick (
    .clk_50MHz (clk_50MHz),
    .rst       (rst),
    .restart   (w_start_det),
    .tick      (w_tick)
  );

  assign w_rx        = r_sync2;
  assign w_fall      = r_rx_prev & ~w_rx;
  assign w_start_det = (r_state == ST_IDLE) && w_fall;
  assign w_samp_mid  = w_tick && (r_samp_cnt == (MID_SAMPLE - 4'd1));
  assign w_samp_late = w_tick && (r_samp_cnt == MID_SAMPLE);
  assign w_vote      = majority3(r_win[1], r_win[0], w_rx);

  // Two-flop synchronizer plus one history flop for falling-edge detection
  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync1   <= uart_rx;
      r_sync2   <= r_sync1;
      r_rx_prev <= r_sync2;
    end
  end

  // FSM state register
  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_fall) begin
          w_state_next = ST_START;
        end
      end
      ST_START: begin
        if (w_samp_mid) begin
          w_state_next = w_rx ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_samp_late && (r_bit_pos == LAST_DATA_POS)) begin
          w_state_next = ST_STOP;
        end
      end
      ST_STOP: begin
        if (w_samp_late) begin
          w_state_next = w_vote ? ST_IDLE : ST_WAIT_IDLE;
        end
      end
      ST_WAIT_IDLE: begin
        if (w_tick && w_rx && (r_high_cnt == SAMP_LAST)) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // FSM output decode: strobe requests and key decode for the completed frame
  always_comb begin
    w_byte_ok  = 1'b0;
    w_byte_bad = 1'b0;
    w_key_next = 4'b0000;
    if ((r_state == ST_STOP) && w_samp_late) begin
      w_byte_ok  = w_vote;
      w_byte_bad = ~w_vote;
      if (w_vote) begin
        w_key_next = key_decode(r_shift);
      end
    end
  end

  assign busy = (r_state != ST_IDLE);

  // Sample and bit-period counters, aligned to the detected falling edge
  always_ff @(posedge clk_50MHz) begin
    if (rst || w_start_det) begin
      r_samp_cnt <= '0;
      r_bit_pos  <= '0;
    end else if (w_tick && (r_state != ST_IDLE)) begin
      r_samp_cnt <= r_samp_cnt + 1'b1;
      if (r_samp_cnt == SAMP_LAST) begin
        r_bit_pos <= r_bit_pos + 4'd1;
      end
    end
  end

  // Vote window history and LSB-first shift register
  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      r_win   <= 2'b11;
      r_shift <= '0;
    end else begin
      if (w_tick) begin
        r_win <= {r_win[0], w_rx};
      end
      // Position 0 is the start bit; its late sample is ignored
      if ((r_state == ST_DATA) && w_samp_late && (r_bit_pos != 4'd0)) begin
        r_shift <= {w_vote, r_shift[7:1]};
      end
    end
  end

  // Consecutive high-tick counter used to leave WAIT_IDLE after a line fault
  always_ff @(posedge clk_50MHz) begin
    if (rst || (r_state != ST_WAIT_IDLE) || !w_rx) begin
      r_high_cnt <= '0;
    end else if (w_tick) begin
      r_high_cnt <= r_high_cnt + 4'd1;
    end
  end

  // Registered outputs: data held between good bytes, strobes for one cycle
  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      r_dataout <= '0;
      r_rdsig   <= 1'b0;
      r_ferr    <= 1'b0;
      r_key     <= 4'b0000;
    end else begin
      r_rdsig <= w_byte_ok;
      r_ferr  <= w_byte_bad;
      r_key   <= w_key_next;
      if (w_byte_ok) begin
        r_dataout <= r_shift;
      end
    end
  end

  assign uart_dataout = r_dataout;
  assign uart_rdsig   = r_rdsig;
  assign frame_err    = r_ferr;
  assign key_hit      = r_key;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_key.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_uart_rx_key
//  Description : Self-checking bench for uart_rx_key at 16 clocks per bit.
//                A frame-level model derives every expected output from the
//                recorded line history; directed tests pin key values.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_rx_key;

  localparam int CLK_FREQ = 1_600_000;
  localparam int BAUD     = 100_000;
  localparam int MAXC     = 16384;

  logic       clk_50MHz = 1'b0;
  logic       rst       = 1'b1;
  logic       uart_rx   = 1'b1;
  logic [7:0] uart_dataout;
  logic       uart_rdsig;
  logic       frame_err;
  logic [3:0] key_hit;
  logic       busy;

  uart_rx_key #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) dut (
    .clk_50MHz    (clk_50MHz),
    .rst          (rst),
    .uart_rx      (uart_rx),
    .uart_dataout (uart_dataout),
    .uart_rdsig   (uart_rdsig),
    .frame_err    (frame_err),
    .key_hit      (key_hit),
    .busy         (busy)
  );

  always #5 clk_50MHz = ~clk_50MHz;

  int cyc = 0;
  always @(posedge clk_50MHz) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
  endtask

  // ---------------- line history and frame-level model ----------------
  // line_h[p] / rst_h[p]: uart_rx / rst as seen by the posedge that ends cycle p-1
  bit line_h [MAXC];
  bit rst_h  [MAXC];

  // Synchronized line as the receiver sees it during cycle i (two flops, reset to 1)
  function automatic bit s_at(input int i);
    if (i < 2 || i >= MAXC) return 1'b1;
    if (rst_h[i] || rst_h[i-1]) return 1'b1;
    return line_h[i-1];
  endfunction

  function automatic bit maj(input bit a, input bit b, input bit c);
    return (int'(a) + int'(b) + int'(c)) >= 2;
  endfunction

  function automatic logic [3:0] exp_key(input logic [7:0] b);
    int v;
    v = int'(b);
    if (v >= 49 && v <= 52) return 4'(1 << (v - 49));
    return 4'b0000;
  endfunction

  // Model state: 0 idle, 1 receiving frame (start detected at fstart), 2 waiting for idle line
  int         m_mode = 0;
  int         m_fstart = 0;
  int         m_hrun = 0;
  bit         pend_rd = 0;
  bit         pend_fe = 0;
  logic [7:0] pend_byte = 8'h00;
  logic [7:0] exp_data = 8'h00;
  bit         e_rd, e_fe, e_busy;
  logic [3:0] e_key;

  initial begin : model
    int c;
    bit sc;
    logic [7:0] b;
    for (int i = 0; i < MAXC; i++) begin
      line_h[i] = 1'b1;
      rst_h[i]  = 1'b1;
    end
    forever begin
      @(negedge clk_50MHz);
      c = cyc;
      if (c + 1 < MAXC) begin
        line_h[c+1] = uart_rx;
        rst_h[c+1]  = rst;
      end
      if (c >= 1 && c < MAXC) begin
        // Outputs visible this cycle follow from decisions taken last cycle
        if (rst_h[c]) begin
          m_mode = 0; pend_rd = 0; pend_fe = 0;
          e_rd = 0; e_fe = 0; e_key = 4'b0000; exp_data = 8'h00;
        end else begin
          e_rd  = pend_rd;
          e_fe  = pend_fe;
          e_key = pend_rd ? exp_key(pend_byte) : 4'b0000;
          if (pend_rd) exp_data = pend_byte;
          pend_rd = 0; pend_fe = 0;
        end
        e_busy = (m_mode != 0);
        check("uart_rdsig",   {31'd0, uart_rdsig}, {31'd0, e_rd});
        check("frame_err",    {31'd0, frame_err},  {31'd0, e_fe});
        check("key_hit",      {28'd0, key_hit},    {28'd0, e_key});
        check("uart_dataout", {24'd0, uart_dataout}, {24'd0, exp_data});
        check("busy",         {31'd0, busy},       {31'd0, e_busy});

        // Decisions taken during cycle c (frame timing relative to start cycle n:
        // start checked at n+9, bit b voted over n+16b+8..n+16b+10, stop at b=9)
        sc = s_at(c);
        case (m_mode)
          0: if (!sc && s_at(c-1)) begin m_mode = 1; m_fstart = c; end
          1: begin
            if (c == m_fstart + 9 && sc) begin
              m_mode = 0;
            end else if (c == m_fstart + 154) begin
              for (int bi = 1; bi <= 8; bi++)
                b[bi-1] = maj(s_at(m_fstart+16*bi+8), s_at(m_fstart+16*bi+9), s_at(m_fstart+16*bi+10));
              if (maj(s_at(m_fstart+152), s_at(m_fstart+153), sc)) begin
                pend_rd = 1; pend_byte = b; m_mode = 0;
              end else begin
                pend_fe = 1; m_mode = 2; m_hrun = 0;
              end
            end
          end
          default: begin
            if (sc) m_hrun++; else m_hrun = 0;
            if (m_hrun == 16) m_mode = 0;
          end
        endcase
      end
    end
  end

  // ---------------- strobe capture for literal checks ----------------
  int         rd_count = 0;
  int         fe_count = 0;
  int         last_rd_cyc = 0;
  logic [7:0] byte_q[$];
  logic [3:0] key_q[$];

  always @(negedge clk_50MHz) begin
    if (uart_rdsig === 1'b1) begin
      rd_count++;
      last_rd_cyc = cyc;
      byte_q.push_back(uart_dataout);
      key_q.push_back(key_hit);
    end
    if (frame_err === 1'b1) fe_count++;
  end

  // ---------------- stimulus ----------------
  int t_frame = 0;

  // Drive one line value for one clock
  task automatic put(input bit v);
    @(posedge clk_50MHz);
    #1;
    uart_rx = v;
  endtask

  task automatic idle(input int n);
    repeat (n) put(1'b1);
  endtask

  // Send one 8N1 frame; optional one-clock inverted spike; optional reset after abort_at clocks
  task automatic send(input logic [7:0] b, input bit stop_ok, input int sp_bit,
                      input int sp_off, input int abort_at);
    logic [9:0] fr;
    bit v;
    int j;
    bit aborted;
    fr = {stop_ok, b, 1'b0};
    j = 0;
    aborted = 0;
    for (int bi = 0; bi < 10; bi++) begin
      for (int o = 0; o < 16; o++) begin
        if (!aborted) begin
          if (j == abort_at) begin
            @(posedge clk_50MHz);
            #1;
            rst = 1'b1;
            uart_rx = 1'b1;
            idle(2);
            @(posedge clk_50MHz);
            #1;
            rst = 1'b0;
            aborted = 1;
          end else begin
            v = fr[bi];
            if (bi == sp_bit && o == sp_off) v = ~v;
            put(v);
            if (j == 0) t_frame = cyc;
            j++;
          end
        end
      end
    end
  endtask

  initial begin : driver
    int q;
    int waited;
    logic [7:0] rb;
    idle(5);
    rst = 1'b0;
    idle(20);

    // 1: key '1'
    send(8'h31, 1'b1, -1, 0, -1);
    idle(20);
    check("t1_count",   rd_count, 1);
    check("t1_data",    byte_q[0], 8'h31);
    check("t1_key",     key_q[0], 4'b0001);
    check("t1_latency", last_rd_cyc - t_frame, 157);
    check("t1_ferr",    fe_count, 0);

    // 2: back-to-back frames, no idle gap
    send(8'hA5, 1'b1, -1, 0, -1);
    send(8'h34, 1'b1, -1, 0, -1);
    idle(20);
    check("t2_count", rd_count, 3);
    check("t2_data0", byte_q[1], 8'hA5);
    check("t2_key0",  key_q[1], 4'b0000);
    check("t2_data1", byte_q[2], 8'h34);
    check("t2_key1",  key_q[2], 4'b1000);

    // 3: 4-clock low glitch on an idle line
    repeat (4) put(1'b0);
    idle(30);
    check("t3_count", rd_count, 3);
    check("t3_ferr",  fe_count, 0);
    check("t3_busy",  busy, 1'b0);

    // 4: stop bit low, line held low, then released
    send(8'h55, 1'b0, -1, 0, -1);
    repeat (40) put(1'b0);
    put(1'b1);
    q = cyc;
    waited = 0;
    while (busy !== 1'b0 && waited < 60) begin
      @(negedge clk_50MHz);
      waited++;
    end
    check("t4_idle_delay", cyc - q, 18);
    idle(10);
    check("t4_ferr",  fe_count, 1);
    check("t4_count", rd_count, 3);
    check("t4_data",  uart_dataout, 8'h34);

    // 5: single-clock spike on the centre sample of data bit 3
    send(8'h32, 1'b1, 4, 9, -1);
    idle(20);
    check("t5_count", rd_count, 4);
    check("t5_data",  byte_q[3], 8'h32);
    check("t5_key",   key_q[3], 4'b0010);

    // 6: reset during data bit 5, then a fresh frame
    send(8'h33, 1'b1, -1, 0, 16*6 + 4);
    idle(30);
    check("t6_no_strobe", rd_count, 4);
    send(8'h34, 1'b1, -1, 0, -1);
    idle(20);
    check("t6_count", rd_count, 5);
    check("t6_data",  byte_q[4], 8'h34);
    check("t6_key",   key_q[4], 4'b1000);

    // Randomized frames: mixed key/non-key bytes, occasional bad stop, spikes, gaps
    for (int k = 0; k < 16; k++) begin
      if ($urandom_range(0, 1) == 1) rb = 8'(49 + $urandom_range(0, 3));
      else rb = 8'($urandom_range(0, 255));
      send(rb, ($urandom_range(0, 7) != 0),
           ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 9)) : -1,
           int'($urandom_range(0, 15)), -1);
      idle(int'($urandom_range(0, 24)));
    end
    idle(60);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
